// File: rtl/video_pattern_gen_if.sv
// Pixel bus between the HDMI timing generator and a pixel source.
// The master drives the raster coordinates, and the slave returns the colour for them.
interface video_pattern_gen_if;
  logic [9:0]  cx;
  logic [9:0]  cy;
  logic [23:0] rgb;

  modport master (output cx, output cy, input rgb);
  modport slave  (input cx, input cy, output rgb);
endinterface

// File: rtl/video_pattern_gen.sv
// Test-pattern source for the HDMI encoder. It offers colour bars, a gradient, a checkerboard and LFSR noise.
// A debounced button selects the pattern, and the selection changes only on frame boundaries.
module video_pattern_gen #(
  parameter int FRAME_WIDTH     = 800,
  parameter int FRAME_HEIGHT    = 525,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int DEBOUNCE_CYCLES = 252000
) (
  input  logic                clk_pixel,
  input  logic                rst_n,
  video_pattern_gen_if.slave  pix,
  input  logic                btn,
  output logic [1:0]          mode,
  output logic [7:0]          frame_count
);

  localparam int BAR_W     = SCREEN_WIDTH / 8;
  localparam int BAR_CNT_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);

  // This is a maximal-length 24-bit Fibonacci LFSR with taps at 24, 23, 22 and 17.
  function automatic logic [23:0] lfsr_next(input logic [23:0] q);
    lfsr_next = {q[22:0], q[23] ^ q[22] ^ q[21] ^ q[16]};
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      3'd7:    bar_colour = 24'h000000;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  logic                 sync1_r, sync2_r;
  logic                 db_level_r;
  logic [DB_W-1:0]      db_cnt_r;
  logic [1:0]           pending_mode_r;
  logic [1:0]           mode_r;
  logic [7:0]           frame_count_r;
  logic [23:0]          lfsr_r;
  logic [23:0]          rgb_r;
  logic [BAR_CNT_W-1:0] col_cnt_r;
  logic [2:0]           bar_r;

  logic                 db_flip_s;
  logic                 press_s;
  logic                 frame_end_s;
  logic                 active_s;
  logic [BAR_CNT_W-1:0] col_cnt_s;
  logic [2:0]           bar_s;
  logic [7:0]           grad_red_s;
  logic [23:0]          rgb_next_s;

  assign db_flip_s   = (sync2_r != db_level_r) && (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1));
  assign press_s     = db_flip_s && !db_level_r;
  assign frame_end_s = (pix.cx == 10'(FRAME_WIDTH - 1)) && (pix.cy == 10'(FRAME_HEIGHT - 1));
  assign active_s    = (pix.cx < 10'(SCREEN_WIDTH)) && (pix.cy < 10'(SCREEN_HEIGHT));
  assign grad_red_s  = pix.cx[7:0] + frame_count_r;

  // The column counter assumes cx advances by one per cycle and restarts at cx==0, which avoids a divider.
  always_comb begin
    col_cnt_s = '0;
    bar_s     = 3'd0;
    if (pix.cx == 10'd0) begin
      col_cnt_s = '0;
      bar_s     = 3'd0;
    end else if (col_cnt_r == BAR_CNT_W'(BAR_W - 1)) begin
      col_cnt_s = '0;
      bar_s     = (bar_r == 3'd7) ? 3'd7 : bar_r + 3'd1;
    end else begin
      col_cnt_s = col_cnt_r + BAR_CNT_W'(1);
      bar_s     = bar_r;
    end
  end

  // Pattern mux; blanking is forced to black
  always_comb begin
    rgb_next_s = 24'h000000;
    if (active_s) begin
      case (mode_r)
        2'd0:    rgb_next_s = bar_colour(bar_s);
        2'd1:    rgb_next_s = {grad_red_s, pix.cy[7:0], pix.cx[7:0] ^ pix.cy[7:0]};
        2'd2:    rgb_next_s = (pix.cx[5] ^ pix.cy[5] ^ frame_count_r[5]) ? 24'hFFFFFF : 24'h000000;
        2'd3:    rgb_next_s = lfsr_r;
        default: rgb_next_s = 24'h000000;
      endcase
    end else begin
      rgb_next_s = 24'h000000;
    end
  end

  // Button synchronizer and debouncer
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      db_level_r <= 1'b0;
      db_cnt_r   <= '0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      if (sync2_r == db_level_r) begin
        db_cnt_r <= '0;
      end else if (db_flip_s) begin
        db_level_r <= ~db_level_r;
        db_cnt_r   <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end
  end

  // Mode selection and frame counting; mode takes the value of pending_mode from before this edge's press
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      pending_mode_r <= 2'd0;
      mode_r         <= 2'd0;
      frame_count_r  <= 8'd0;
    end else begin
      if (press_s) begin
        pending_mode_r <= pending_mode_r + 2'd1;
      end
      if (frame_end_s) begin
        mode_r        <= pending_mode_r;
        frame_count_r <= frame_count_r + 8'd1;
      end
    end
  end

  // Pixel pipeline: the bar counter, the LFSR (advanced on every active pixel) and the registered colour
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      col_cnt_r <= '0;
      bar_r     <= 3'd0;
      lfsr_r    <= 24'h000001;
      rgb_r     <= 24'h000000;
    end else begin
      col_cnt_r <= col_cnt_s;
      bar_r     <= bar_s;
      rgb_r     <= rgb_next_s;
      if (active_s) begin
        lfsr_r <= lfsr_next(lfsr_r);
      end
    end
  end

  assign pix.rgb     = rgb_r;
  assign mode        = mode_r;
  assign frame_count = frame_count_r;

endmodule
